// File: rtl/alu_booth_mul_seq_pkg.sv
// Shared ALU control codes and multiplier FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_booth_mul_seq_pkg;

  // ALU_control codes understood by the datapath ALU
  localparam logic [3:0] ALU_CTL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTL_SLT = 4'b0111;

  // Multiplier sequencer states
  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

endpackage

// File: rtl/alu.sv
// 32-bit datapath ALU: and/or/add/sub/slt with carry, signed overflow and zero flags.
// Latency: combinational.
// Backpressure: none; result follows inputs every cycle.
module alu
  import alu_booth_mul_seq_pkg::*;
(
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ALU_control,
  output logic [31:0] result,
  output logic        overflow,
  output logic        cout,
  output logic        zero
);

  logic [32:0] sum33;

  // Operation select; outputs are forced quiet while reset is asserted
  always_comb begin
    sum33    = '0;
    result   = '0;
    overflow = 1'b0;
    cout     = 1'b0;
    case (ALU_control)
      ALU_CTL_AND: result = a & b;
      ALU_CTL_OR:  result = a | b;
      ALU_CTL_ADD: begin
        sum33    = {1'b0, a} + {1'b0, b};
        result   = sum33[31:0];
        cout     = sum33[32];
        overflow = (a[31] == b[31]) && (sum33[31] != a[31]);
      end
      ALU_CTL_SUB: begin
        sum33    = {1'b0, a} + {1'b0, ~b} + 33'd1;
        result   = sum33[31:0];
        cout     = sum33[32];
        overflow = (a[31] != b[31]) && (sum33[31] != a[31]);
      end
      ALU_CTL_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      default:     result = '0;
    endcase
    if (!rst_n) begin
      result   = '0;
      overflow = 1'b0;
      cout     = 1'b0;
    end
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_booth_mul_seq.sv
// Signed 32x32->64 radix-2 Booth multiplier sequencing one shared-style ALU.
// Latency: done_o 33 cycles after accepted start (1 cycle when an operand is zero).
// Backpressure: start_i ignored while busy_o; abort_i cancels any operation next edge.
module alu_booth_mul_seq
  import alu_booth_mul_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [DATA_W-1:0]   mcand_i,
  input  logic [DATA_W-1:0]   mplier_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [2*DATA_W-1:0] product_o,
  output logic                prod_zero_o
);

  localparam logic [4:0] CNT_LAST = 5'(DATA_W - 1);

  logic [1:0]        state_q, state_nxt;
  logic [DATA_W-1:0] a_q, a_nxt;
  logic [DATA_W-1:0] q_q, q_nxt;
  logic              qm1_q, qm1_nxt;
  logic [DATA_W-1:0] m_q, m_nxt;
  logic [4:0]        cnt_q, cnt_nxt;
  logic              pz_q;
  logic              upd;

  logic [3:0]        alu_ctl;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              alu_cout;
  logic              alu_zero;
  logic              use_alu;
  logic [DATA_W-1:0] sum;
  logic              sgn;
  logic              unused_alu;

  alu u_alu (
    .rst_n       (rst_n),
    .a           (a_q),
    .b           (m_q),
    .ALU_control (alu_ctl),
    .result      (alu_res),
    .overflow    (alu_ovf),
    .cout        (alu_cout),
    .zero        (alu_zero)
  );

  assign unused_alu = alu_cout ^ alu_zero;

  // Booth recode of {Q[0], q_m1}: 01 add, 10 sub, otherwise keep A. The shifted-in
  // sign comes from sum ^ overflow so M = -2^31 still gives the true sign.
  always_comb begin
    use_alu = (q_q[0] != qm1_q);
    alu_ctl = (q_q[0] && !qm1_q) ? ALU_CTL_SUB : ALU_CTL_ADD;
    sum     = use_alu ? alu_res : a_q;
    sgn     = use_alu ? (alu_res[DATA_W-1] ^ alu_ovf) : a_q[DATA_W-1];
  end

  // Next-state and datapath update; abort overrides every state
  always_comb begin
    state_nxt = state_q;
    a_nxt     = a_q;
    q_nxt     = q_q;
    qm1_nxt   = qm1_q;
    m_nxt     = m_q;
    cnt_nxt   = cnt_q;
    upd       = 1'b0;
    if (abort_i) begin
      state_nxt = MUL_IDLE;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start_i) begin
            m_nxt   = mcand_i;
            a_nxt   = '0;
            q_nxt   = mplier_i;
            qm1_nxt = 1'b0;
            cnt_nxt = '0;
            upd     = 1'b1;
            if (ZERO_SKIP && ((mcand_i == '0) || (mplier_i == '0))) begin
              q_nxt     = '0;
              state_nxt = MUL_DONE;
            end else begin
              state_nxt = MUL_RUN;
            end
          end
        end
        MUL_RUN: begin
          a_nxt   = {sgn, sum[DATA_W-1:1]};
          q_nxt   = {sum[0], q_q[DATA_W-1:1]};
          qm1_nxt = q_q[0];
          cnt_nxt = cnt_q + 5'd1;
          upd     = 1'b1;
          if (cnt_q == CNT_LAST) state_nxt = MUL_DONE;
        end
        MUL_DONE: state_nxt = MUL_IDLE;
        default:  state_nxt = MUL_IDLE;
      endcase
    end
  end

  // State and datapath registers; zero flag tracks {A,Q} only when they are written
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      pz_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      a_q     <= a_nxt;
      q_q     <= q_nxt;
      qm1_q   <= qm1_nxt;
      m_q     <= m_nxt;
      cnt_q   <= cnt_nxt;
      if (upd) pz_q <= ({a_nxt, q_nxt} == '0);
    end
  end

  assign busy_o      = (state_q != MUL_IDLE);
  assign done_o      = (state_q == MUL_DONE);
  assign product_o   = {a_q, q_q};
  assign prod_zero_o = pz_q;

endmodule

// File: tb/tb_alu_booth_mul_seq.sv
// Self-checking bench for alu_booth_mul_seq against a plain signed-multiply model.
// Latency: checks done_o at cycle 33 (1 for zero operands).
// Backpressure: exercises ignored starts, abort and reset mid-run.
module tb_alu_booth_mul_seq;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic [31:0] mcand_i;
  logic [31:0] mplier_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] product_o;
  logic        prod_zero_o;

  int n_tests = 0;
  int n_fail  = 0;

  alu_booth_mul_seq #(.DATA_W(32), .ZERO_SKIP(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .mcand_i     (mcand_i),
    .mplier_i    (mplier_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .product_o   (product_o),
    .prod_zero_o (prod_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    longint a;
    longint b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return 64'(a * b);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Runs one multiply; if poke>0 a stray start with other operands is pulsed in that cycle.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input int poke);
    logic [63:0] exp;
    int          lat;
    int          got_lat;
    int          busy_lo;
    exp      = ref_mul(m, q);
    lat      = (m == 0 || q == 0) ? 1 : 33;
    got_lat  = 0;
    busy_lo  = 0;
    mcand_i  = m;
    mplier_i = q;
    start_i  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (c == poke) begin
        start_i  = 1'b1;
        mcand_i  = ~m;
        mplier_i = q + 32'd1;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) begin
        got_lat = c;
        break;
      end
      if (!busy_o) busy_lo++;
    end
    start_i = 1'b0;
    chk("latency", 64'(got_lat), 64'(lat));
    chk("busy_gap", 64'(busy_lo), 64'd0);
    chk("product", product_o, exp);
    chk("prod_zero", 64'(prod_zero_o), 64'(exp == 64'd0));
    @(negedge clk_i);
    chk("done_pulse", {62'd0, done_o, busy_o}, 64'd0);
    chk("product_hold", product_o, exp);
  endtask

  initial begin
    logic saw;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    mcand_i  = '0;
    mplier_i = '0;
    #2;
    chk("rst_flags", {61'd0, busy_o, done_o, prod_zero_o}, 64'd0);
    chk("rst_product", product_o, 64'd0);
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);

    // Directed cases
    run_op(32'd3, 32'd4, 0);
    chk("t1_value", product_o, 64'h0000_0000_0000_000C);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(32'd7, 32'hFFFF_FFFB, 0);
    chk("t2_value", product_o, 64'hFFFF_FFFF_FFFF_FFDD);
    run_op(32'h8000_0000, 32'h8000_0000, 0);
    chk("t3_value", product_o, 64'h4000_0000_0000_0000);
    run_op(32'h8000_0000, 32'd1, 0);
    chk("t3b_value", product_o, 64'hFFFF_FFFF_8000_0000);
    run_op(32'd0, 32'h1234, 0);
    run_op(32'd6, 32'd7, 10);
    chk("t5_value", product_o, 64'd42);

    // Reset in the middle of a run
    mcand_i  = 32'd6;
    mplier_i = 32'd7;
    start_i  = 1'b1;
    repeat (15) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {61'd0, busy_o, done_o, prod_zero_o}, 64'd0);
    chk("midrst_product", product_o, 64'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);

    // Abort at cycle 20 of a fresh run
    mcand_i  = 32'd5;
    mplier_i = 32'd9;
    start_i  = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("abort_idle", 64'(busy_o), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o || busy_o) saw = 1'b1;
    end
    chk("abort_nodone", 64'(saw), 64'd0);
    run_op(32'd2, 32'd3, 0);
    chk("t6_value", product_o, 64'd6);

    // Abort together with start in IDLE: start must be dropped
    mcand_i  = 32'd9;
    mplier_i = 32'd9;
    start_i  = 1'b1;
    abort_i  = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("abort_start", 64'(busy_o), 64'd0);
    chk("abort_start_prod", product_o, 64'd6);

    // Randomized operands with corner-value bias
    for (int i = 0; i < 40; i++) begin
      run_op(pick(), pick(), (i % 5 == 0) ? 1 + (i % 30) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
